regaddr_mux5: RTL and testbench
===============================

// Module: regaddr_mux5
// PURPOSE
//   2:1 selector for 5-bit register addresses; picks the register-file write address (rt vs rd) in the datapath.
//   Provides a combinational result plus a registered copy with load enable and zero-address flag.
//   The registered path feeds the next pipeline/write stage.
//   r = sel ? b : a is the primary contract. The registered outputs are additive.
// PARAMETERS
//   WIDTH      5       data/address width of a, b, r, r_q
//   RST_VAL    0       value loaded into r_q on reset (WIDTH bits)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      reset, asynchronous, active-low
//   sel        in   1      select: 0 -> a, 1 -> b
//   a          in   WIDTH  input 0
//   b          in   WIDTH  input 1
//   en         in   1      load enable for registered path
//   r          out  WIDTH  combinational result
//   r_q        out  WIDTH  registered result
//   r_q_zero   out  1      high when r_q == 0 (register $0; write must be suppressed downstream)
//   r_q_chg    out  1      high for one cycle after a load that changed r_q's value
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - r = (sel == 1'b1) ? b : a; purely combinational, zero latency, all WIDTH bits, no truncation or extension.
//   - sel X/Z: r follows a (only a definite 1 selects b).
//   - r is not affected by reset, clk or en.
//   - rst_n low (any time, independent of clk):
//     - r_q = RST_VAL; r_q_zero = (RST_VAL == 0); r_q_chg = 0.
//     - Holds while rst_n is low.
//   - Rising clk, rst_n high:
//     - en=1: r_q <= r (value of r at that edge); r_q_chg <= (r != old r_q).
//     - en=0: r_q holds; r_q_chg <= 0.
//   - r_q_zero is combinational from r_q (no extra cycle), so it is valid the same cycle r_q updates.
//   - Latency: r = 0 cycles; r_q, r_q_chg = 1 cycle after the en edge.
//   - Reset release: first load occurs on the first rising clk with rst_n high and en=1.
//   - Reset mid-operation: r_q returns to RST_VAL immediately; pending load is discarded.
//   - sel/a/b changing during en=1: the value sampled at the clock edge wins; intermediate glitches are never captured.
// TESTING
//   1. sel=0, a=5'b01010, b=5'b10101 -> r=5'b01010 within same delta; hold 50 time units, stable.
//   2. sel=1, a=5'b01010, b=5'b10101 -> r=5'b10101.
//   3. sel=0, a=5'b00000, b=5'b11111 -> r=5'b00000. Then sel=1 -> r=5'b11111 (full-width check, all bits toggle).
//   4. rst_n=0 asynchronously mid-cycle with r_q=5'b10101 -> r_q=0, r_q_zero=1, r_q_chg=0 immediately; r unaffected.
//   5. rst_n=1, en=1, sel=1, b=5'b11111, clk edge -> r_q=5'b11111, r_q_zero=0, r_q_chg=1.
//      Next edge with same input -> r_q_chg=0.
//   6. en=0, change a/b/sel over 3 clocks -> r tracks inputs; r_q holds 5'b11111; r_q_chg stays 0.

Source files
------------

// File: rtl/regaddr_mux5.sv
// Register-file write-address selector: combinational rt/rd pick plus a
// load-enabled registered copy with zero-register and value-changed flags.
module regaddr_mux5 #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q,
  output logic             r_q_zero,
  output logic             r_q_chg
);

  logic [WIDTH-1:0] r_q_d;
  logic [WIDTH-1:0] r_q_q;
  logic             r_q_chg_d;
  logic             r_q_chg_q;

  // Only a definite 1 on sel picks b; an unknown select falls back to a.
  always_comb begin
    r = a;
    if (sel === 1'b1) begin
      r = b;
    end
  end

  // en is a single-cycle load strobe: whatever r shows at the rising edge
  // where en is high is captured; there is no backpressure.
  always_comb begin
    r_q_d     = r_q_q;
    r_q_chg_d = 1'b0;
    if (en) begin
      r_q_d     = r;
      r_q_chg_d = (r != r_q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_q     <= RST_VAL;
      r_q_chg_q <= 1'b0;
    end else begin
      r_q_q     <= r_q_d;
      r_q_chg_q <= r_q_chg_d;
    end
  end

  assign r_q      = r_q_q;
  // Decoded straight from the register so it is valid in the same cycle.
  assign r_q_zero = (r_q_q == '0);
  assign r_q_chg  = r_q_chg_q;

endmodule

// File: tb/tb_regaddr_mux5.sv
// Bench for regaddr_mux5: directed cases plus random traffic, checked by a
// queue-based scoreboard against a simple register model.
module tb_regaddr_mux5;

  localparam int              W       = 5;
  localparam int              EW      = W + 2;
  localparam logic [W-1:0]    RST_VAL = '0;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         en;
  logic [W-1:0] r;
  logic [W-1:0] r_q;
  logic         r_q_zero;
  logic         r_q_chg;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  model_reg;
  int            n_checks;
  int            n_pass;
  bit            stream_done;

  regaddr_mux5 #(.WIDTH(W), .RST_VAL(RST_VAL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .a        (a),
    .b        (b),
    .en       (en),
    .r        (r),
    .r_q      (r_q),
    .r_q_zero (r_q_zero),
    .r_q_chg  (r_q_chg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver: apply one cycle of inputs, check r, push expected registered result
  task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic e);
    logic [W-1:0] exp_r;
    logic         exp_chg;
    @(negedge clk);
    sel = s; a = av; b = bv; en = e;
    #1;
    exp_r = s ? bv : av;
    check("r_comb", 32'(r), 32'(exp_r));
    exp_chg = 1'b0;
    if (e) begin
      exp_chg   = (exp_r != model_reg);
      model_reg = exp_r;
    end
    exp_q.push_back({model_reg, (model_reg == '0), exp_chg});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_q"},    32'(r_q),      32'(RST_VAL));
    check({tag, "_zero"},   32'(r_q_zero), 32'(RST_VAL == '0));
    check({tag, "_chg"},    32'(r_q_chg),  32'd0);
  endtask

  // reset asserted between edges; optionally with a load armed for the next edge
  task automatic mid_reset(input logic armed);
    logic [W-1:0] r_before;
    @(negedge clk);
    if (armed) begin
      sel = 1'b1; a = 5'b00110; b = 5'b10101; en = 1'b1;
    end
    #2;
    r_before = (sel === 1'b1) ? b : a;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("rst_r_unaffected", 32'(r), 32'(r_before));
    model_reg = RST_VAL;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("r_q",      32'(r_q),      32'(e[EW-1:2]));
        check("r_q_zero", 32'(r_q_zero), 32'(e[1]));
        check("r_q_chg",  32'(r_q_chg),  32'(e[0]));
      end
    end
  end

  // stimulus
  initial begin
    n_checks = 0; n_pass = 0; stream_done = 1'b0;
    model_reg = RST_VAL;
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; a = '0; b = '0;
    #3;
    check_reset_outputs("por");
    en = 1'b1; sel = 1'b1; b = 5'b11111;
    @(posedge clk);
    #1;
    check_reset_outputs("por_hold_en");
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;

    // select a, held stable over five cycles
    for (int i = 0; i < 5; i++) drive(1'b0, 5'b01010, 5'b10101, 1'b0);
    drive(1'b1, 5'b01010, 5'b10101, 1'b0);
    drive(1'b0, 5'b00000, 5'b11111, 1'b0);
    drive(1'b1, 5'b00000, 5'b11111, 1'b0);

    // load 10101 then reset asynchronously mid-cycle
    drive(1'b1, 5'b01010, 5'b10101, 1'b1);
    mid_reset(1'b0);

    // first load after release, then same value again
    drive(1'b1, 5'b00000, 5'b11111, 1'b1);
    drive(1'b1, 5'b00000, 5'b11111, 1'b1);

    // en low: r tracks, r_q holds
    for (int i = 0; i < 3; i++)
      drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0);

    // a load armed for the next edge is discarded by reset
    mid_reset(1'b1);

    // load zero register, then a nonzero one
    drive(1'b0, 5'b00000, 5'b00001, 1'b1);
    drive(1'b1, 5'b00000, 5'b00001, 1'b1);

    // random traffic with biased zero addresses
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      av = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      bv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) bv = av;
      drive(1'($urandom_range(0, 1)), av, bv, 1'($urandom_range(0, 3) != 0));
    end
    stream_done = 1'b1;
  end

  // drain and report
  initial begin
    wait (stream_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL timeout: stimulus did not complete by %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
